// File: rtl/psg_mixer_pkg.sv
// Shared definitions for the dual-PSG stereo mixer: mode encodings, FSM states,
// level constants and the per-channel panning helper.
package psg_mixer_pkg;

    localparam int CHAN_W   = 12;
    localparam int SAMPLE_W = 14;
    localparam int ACC_W    = 15;

    localparam logic [1:0] MODE_MONO = 2'b00;
    localparam logic [1:0] MODE_ABC  = 2'b01;
    localparam logic [1:0] MODE_ACB  = 2'b10;

    localparam logic [SAMPLE_W-1:0] SAT_MAX    = 14'd16383;
    localparam logic [CHAN_W-1:0]   BEEP_LEVEL = 12'd4095;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        OUT  = 2'd2
    } state_t;

    typedef struct packed {
        logic [ACC_W-1:0] l;
        logic [ACC_W-1:0] r;
    } contrib_t;

    // chan: 0 = A, 1 = B, 2 = C. Mode 11 falls through to mono.
    function automatic contrib_t chan_contrib(input logic [1:0] mode,
                                              input logic [1:0] chan,
                                              input logic [CHAN_W-1:0] level);
        contrib_t         c;
        logic [ACC_W-1:0] full;
        logic [ACC_W-1:0] half;
        full = {3'b000, level};
        half = {4'b0000, level[CHAN_W-1:1]};
        c.l  = full;
        c.r  = full;
        case (mode)
            MODE_ABC: begin
                case (chan)
                    2'd0:    begin c.l = full;     c.r = '0;   end
                    2'd1:    begin c.l = half;     c.r = half; end
                    default: begin c.l = '0;       c.r = full; end
                endcase
            end
            MODE_ACB: begin
                case (chan)
                    2'd0:    begin c.l = full;     c.r = '0;   end
                    2'd1:    begin c.l = '0;       c.r = full; end
                    default: begin c.l = half;     c.r = half; end
                endcase
            end
            default: begin
                c.l = full;
                c.r = full;
            end
        endcase
        return c;
    endfunction

    function automatic logic [SAMPLE_W-1:0] sat14(input logic [ACC_W-1:0] v);
        return (v > {1'b0, SAT_MAX}) ? SAT_MAX : v[SAMPLE_W-1:0];
    endfunction

endpackage

// File: rtl/psg_mixer_sigma_delta_dac.sv
// First-order sigma-delta DAC: the carry out of a WIDTH-bit phase accumulator
// is the bitstream, so the ones density equals sample / 2**WIDTH.
module sigma_delta_dac #(
    parameter int WIDTH = 14
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] sample,
    output logic             pdm
);

    logic [WIDTH:0] acc_q;
    logic [WIDTH:0] acc_d;

    always_comb begin
        acc_d = {1'b0, acc_q[WIDTH-1:0]} + {1'b0, sample};
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign pdm = acc_q[WIDTH];

endmodule

// File: rtl/psg_mixer.sv
// Dual-PSG stereo mixer: serially accumulates six channels plus beeper, one per
// clock, then saturates to 14 bits. Define TURBOSOUND_EN to mix the second PSG.
module psg_mixer
    import psg_mixer_pkg::*;
(
    input  logic                clock,
    input  logic                reset,
    input  logic                ce,
    input  logic [1:0]          mode,
    input  logic [CHAN_W-1:0]   a1,
    input  logic [CHAN_W-1:0]   b1,
    input  logic [CHAN_W-1:0]   c1,
    input  logic [CHAN_W-1:0]   a2,
    input  logic [CHAN_W-1:0]   b2,
    input  logic [CHAN_W-1:0]   c2,
    input  logic                beep,
    output logic [SAMPLE_W-1:0] left,
    output logic [SAMPLE_W-1:0] right,
    output logic                valid,
    output logic                pdm_l,
    output logic                pdm_r
);

`ifdef TURBOSOUND_EN
    localparam int NUM_CH = 6;
`else
    localparam int NUM_CH = 3;
    // Second PSG is deliberately left unconnected in this build.
    logic unused_psg2;
    assign unused_psg2 = ^{a2, b2, c2};
`endif

    state_t                          state_q, state_d;
    logic [2:0]                      step_q, step_d;
    logic [ACC_W-1:0]                acc_l_q, acc_l_d;
    logic [ACC_W-1:0]                acc_r_q, acc_r_d;
    logic [NUM_CH-1:0][CHAN_W-1:0]   snap_q, snap_d;
    logic                            beep_q, beep_d;
    logic [1:0]                      mode_q, mode_d;
    logic [SAMPLE_W-1:0]             left_q, left_d;
    logic [SAMPLE_W-1:0]             right_q, right_d;
    logic                            valid_q, valid_d;

    logic [CHAN_W-1:0]               level;
    logic [1:0]                      chan;
    contrib_t                        add;
    logic [ACC_W-1:0]                sum_l;
    logic [ACC_W-1:0]                sum_r;

    // Source selection for the current step; steps 3-5 contribute zero
    // when the second PSG is not built in.
    always_comb begin
        level = '0;
        chan  = 2'd0;
        case (step_q)
            3'd0: begin level = snap_q[0]; chan = 2'd0; end
            3'd1: begin level = snap_q[1]; chan = 2'd1; end
            3'd2: begin level = snap_q[2]; chan = 2'd2; end
`ifdef TURBOSOUND_EN
            3'd3: begin level = snap_q[3]; chan = 2'd0; end
            3'd4: begin level = snap_q[4]; chan = 2'd1; end
            3'd5: begin level = snap_q[5]; chan = 2'd2; end
`else
            3'd3: begin level = '0; chan = 2'd0; end
            3'd4: begin level = '0; chan = 2'd1; end
            3'd5: begin level = '0; chan = 2'd2; end
`endif
            default: begin level = '0; chan = 2'd0; end
        endcase

        if (step_q == 3'd6) begin
            add.l = beep_q ? {3'b000, BEEP_LEVEL} : '0;
            add.r = add.l;
        end else begin
            add = chan_contrib(mode_q, chan, level);
        end

        sum_l = acc_l_q + add.l;
        sum_r = acc_r_q + add.r;
    end

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        acc_l_d = acc_l_q;
        acc_r_d = acc_r_q;
        snap_d  = snap_q;
        beep_d  = beep_q;
        mode_d  = mode_q;
        left_d  = left_q;
        right_d = right_q;
        valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (ce) begin
`ifdef TURBOSOUND_EN
                    snap_d = {c2, b2, a2, c1, b1, a1};
`else
                    snap_d = {c1, b1, a1};
`endif
                    beep_d  = beep;
                    mode_d  = mode;
                    acc_l_d = '0;
                    acc_r_d = '0;
                    step_d  = 3'd0;
                    state_d = ACC;
                end
            end
            ACC: begin
                acc_l_d = sum_l;
                acc_r_d = sum_r;
                if (step_q == 3'd6) begin
                    // Saturated result is registered on the edge into OUT so
                    // that left/right change in the same cycle valid is high.
                    left_d  = sat14(sum_l);
                    right_d = sat14(sum_r);
                    valid_d = 1'b1;
                    step_d  = 3'd0;
                    state_d = OUT;
                end else begin
                    step_d = step_q + 3'd1;
                end
            end
            OUT: begin
                step_d  = 3'd0;
                state_d = IDLE;
            end
            default: begin
                step_d  = 3'd0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= IDLE;
            step_q  <= '0;
            acc_l_q <= '0;
            acc_r_q <= '0;
            snap_q  <= '0;
            beep_q  <= 1'b0;
            mode_q  <= MODE_MONO;
            left_q  <= '0;
            right_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            acc_l_q <= acc_l_d;
            acc_r_q <= acc_r_d;
            snap_q  <= snap_d;
            beep_q  <= beep_d;
            mode_q  <= mode_d;
            left_q  <= left_d;
            right_q <= right_d;
            valid_q <= valid_d;
        end
    end

    assign left  = left_q;
    assign right = right_q;
    assign valid = valid_q;

    sigma_delta_dac #(.WIDTH(SAMPLE_W)) u_dac_l (
        .clock  (clock),
        .reset  (reset),
        .sample (left_q),
        .pdm    (pdm_l)
    );

    sigma_delta_dac #(.WIDTH(SAMPLE_W)) u_dac_r (
        .clock  (clock),
        .reset  (reset),
        .sample (right_q),
        .pdm    (pdm_r)
    );

endmodule

// File: tb/tb_psg_mixer.sv
// Self-checking bench for psg_mixer: vector table, random mixes against a
// behavioural model, and hand sequences for ce overlap, reset abort and the DAC.
module tb_psg_mixer;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        ce    = 1'b0;
    logic [1:0]  mode  = 2'd0;
    logic [11:0] a1 = '0, b1 = '0, c1 = '0, a2 = '0, b2 = '0, c2 = '0;
    logic        beep  = 1'b0;
    logic [13:0] left, right;
    logic        valid, pdm_l, pdm_r;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0]  mode;
        logic [11:0] a1, b1, c1, a2, b2, c2;
        logic        beep;
        int          el;
        int          er;
    } vec_t;

    always #5 clock = ~clock;

    psg_mixer dut (
        .clock (clock), .reset (reset), .ce (ce), .mode (mode),
        .a1 (a1), .b1 (b1), .c1 (c1), .a2 (a2), .b2 (b2), .c2 (c2),
        .beep (beep), .left (left), .right (right), .valid (valid),
        .pdm_l (pdm_l), .pdm_r (pdm_r)
    );

    task automatic check(input string name, input int tag, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %0d, expected %0d", name, tag, act, exp);
        end
    endtask

    // Reference: mix rules in plain integer arithmetic.
    function automatic void model(input vec_t v, output int l, output int r);
        int a[2], b[2], c[2];
        int npsg;
`ifdef TURBOSOUND_EN
        npsg = 2;
`else
        npsg = 1;
`endif
        a[0] = int'(v.a1); b[0] = int'(v.b1); c[0] = int'(v.c1);
        a[1] = int'(v.a2); b[1] = int'(v.b2); c[1] = int'(v.c2);
        l = 0;
        r = 0;
        for (int p = 0; p < npsg; p++) begin
            if (v.mode == 2'b01) begin
                l += a[p] + b[p] / 2;
                r += c[p] + b[p] / 2;
            end else if (v.mode == 2'b10) begin
                l += a[p] + c[p] / 2;
                r += b[p] + c[p] / 2;
            end else begin
                l += a[p] + b[p] + c[p];
                r += a[p] + b[p] + c[p];
            end
        end
        if (v.beep) begin
            l += 4095;
            r += 4095;
        end
        if (l > 16383) l = 16383;
        if (r > 16383) r = 16383;
    endfunction

    task automatic apply(input vec_t v);
        mode = v.mode; beep = v.beep;
        a1 = v.a1; b1 = v.b1; c1 = v.c1; a2 = v.a2; b2 = v.b2; c2 = v.c2;
    endtask

    task automatic scramble();
        mode = 2'($urandom); beep = 1'($urandom);
        a1 = 12'($urandom); b1 = 12'($urandom); c1 = 12'($urandom);
        a2 = 12'($urandom); b2 = 12'($urandom); c2 = 12'($urandom);
    endtask

    // One ce pulse in cycle 0; inputs are scrambled right after the snapshot.
    task automatic do_mix(input vec_t v, input int tag);
        int cyc;
        bit got;
        @(negedge clock);
        apply(v);
        ce = 1'b1;
        @(negedge clock);
        ce = 1'b0;
        scramble();
        cyc = 1;
        got = 1'b0;
        while (!got && cyc <= 20) begin
            if (valid) got = 1'b1;
            else begin
                @(negedge clock);
                cyc++;
            end
        end
        check("valid_seen", tag, int'(got), 1);
        check("latency", tag, cyc, 8);
        check("left", tag, int'(left), v.el);
        check("right", tag, int'(right), v.er);
        @(negedge clock);
        check("valid_one_cycle", tag, int'(valid), 0);
        check("left_hold", tag, int'(left), v.el);
        check("right_hold", tag, int'(right), v.er);
    endtask

    vec_t tbl[9];
    vec_t v;

    initial begin
        int nvalid, vcyc, ones_l, ones_r, el, er;

        tbl[0] = '{2'd1, 12'd4095, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0, 1'b0, 4095, 0};
        tbl[1] = '{2'd2, 12'd0, 12'd0, 12'd1000, 12'd0, 12'd0, 12'd0, 1'b0, 500, 500};
`ifdef TURBOSOUND_EN
        tbl[2] = '{2'd0, 12'd4095, 12'd4095, 12'd4095, 12'd4095, 12'd4095, 12'd4095, 1'b1, 16383, 16383};
        tbl[3] = '{2'd0, 12'd0, 12'd0, 12'd0, 12'd4095, 12'd0, 12'd0, 1'b0, 4095, 4095};
        tbl[8] = '{2'd1, 12'd4095, 12'd4095, 12'd4095, 12'd4095, 12'd4095, 12'd4095, 1'b1, 16379, 16379};
`else
        tbl[2] = '{2'd0, 12'd4095, 12'd4095, 12'd4095, 12'd4095, 12'd4095, 12'd4095, 1'b1, 16380, 16380};
        tbl[3] = '{2'd0, 12'd0, 12'd0, 12'd0, 12'd4095, 12'd0, 12'd0, 1'b0, 0, 0};
        tbl[8] = '{2'd1, 12'd4095, 12'd4095, 12'd4095, 12'd4095, 12'd4095, 12'd4095, 1'b1, 10237, 10237};
`endif
        tbl[4] = '{2'd0, 12'd100, 12'd200, 12'd300, 12'd0, 12'd0, 12'd0, 1'b0, 600, 600};
        tbl[5] = '{2'd1, 12'd10, 12'd21, 12'd30, 12'd0, 12'd0, 12'd0, 1'b0, 20, 40};
        tbl[6] = '{2'd2, 12'd10, 12'd21, 12'd31, 12'd0, 12'd0, 12'd0, 1'b0, 25, 36};
        tbl[7] = '{2'd3, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0, 1'b1, 4095, 4095};

        // Reset state
        repeat (3) @(negedge clock);
        check("rst_left", 0, int'(left), 0);
        check("rst_right", 0, int'(right), 0);
        check("rst_valid", 0, int'(valid), 0);
        check("rst_pdm_l", 0, int'(pdm_l), 0);
        check("rst_pdm_r", 0, int'(pdm_r), 0);
        reset = 1'b1;

        for (int i = 0; i < 9; i++) do_mix(tbl[i], i);

        for (int i = 0; i < 40; i++) begin
            v.mode = 2'($urandom); v.beep = 1'($urandom);
            v.a1 = 12'($urandom); v.b1 = 12'($urandom); v.c1 = 12'($urandom);
            v.a2 = 12'($urandom); v.b2 = 12'($urandom); v.c2 = 12'($urandom);
            if (i % 4 == 0) begin
                v.a1 = 12'd4095; v.b1 = 12'd4095; v.c1 = 12'd4095; v.beep = 1'b1;
            end
            model(v, el, er);
            v.el = el;
            v.er = er;
            do_mix(v, 100 + i);
        end

        // ce at cycles 0, 3 and 8 (ACC and OUT): one valid, at cycle 8
        @(negedge clock);
        v = '{2'd0, 12'd7, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0, 1'b0, 7, 7};
        apply(v);
        ce = 1'b1;
        nvalid = 0;
        vcyc = -1;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clock);
            ce = (c == 3 || c == 8);
            if (valid) begin
                nvalid++;
                vcyc = c;
            end
        end
        check("overlap_count", 0, nvalid, 1);
        check("overlap_cycle", 0, vcyc, 8);
        check("overlap_left", 0, int'(left), 7);

        // Reset at cycle 4 aborts the sequence
        @(negedge clock);
        apply(tbl[4]);
        ce = 1'b1;
        nvalid = 0;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clock);
            ce = 1'b0;
            if (c == 4) reset = 1'b0;
            if (c == 5) reset = 1'b1;
            if (valid) nvalid++;
        end
        check("abort_valid", 0, nvalid, 0);
        check("abort_left", 0, int'(left), 0);
        check("abort_right", 0, int'(right), 0);
        do_mix(tbl[5], 200);

        // DAC density at left = right = 8192
        v = '{2'd0, 12'd4095, 12'd4095, 12'd2, 12'd0, 12'd0, 12'd0, 1'b0, 8192, 8192};
        do_mix(v, 300);
        ones_l = 0;
        ones_r = 0;
        for (int c = 0; c < 1024; c++) begin
            @(negedge clock);
            ones_l += int'(pdm_l);
            ones_r += int'(pdm_r);
        end
        check("pdm_l_ones_in_511_513", ones_l, int'(ones_l >= 511 && ones_l <= 513), 1);
        check("pdm_r_ones_in_511_513", ones_r, int'(ones_r >= 511 && ones_r <= 513), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/psg_mixer.md
PSG_MIXER -- requirements
Module: psg_mixer

Interface
REQ-001 The module SHALL have port `clock`, input, 1 bit: system clock; all logic is clocked on its rising edge.
REQ-002 The module SHALL have port `reset`, input, 1 bit: synchronous, active-low reset.
REQ-003 The module SHALL have port `ce`, input, 1 bit: sample strobe; one pulse starts one mix sequence.
REQ-004 The module SHALL have port `mode`, input, 2 bits: stereo mode; 00 mono, 01 ABC, 10 ACB, 11 treated as mono.
REQ-005 The module SHALL have ports `a1`, `b1`, `c1`, inputs, 12 bits each: PSG 1 channel levels, unsigned.
REQ-006 The module SHALL have ports `a2`, `b2`, `c2`, inputs, 12 bits each: PSG 2 channel levels, unsigned.
REQ-007 The module SHALL have port `beep`, input, 1 bit: beeper/ear level.
REQ-008 The module SHALL have ports `left`, `right`, outputs, 14 bits each: mixed samples, unsigned, registered.
REQ-009 The module SHALL have port `valid`, output, 1 bit: single-cycle pulse when `left`/`right` update.
REQ-010 The module SHALL have ports `pdm_l`, `pdm_r`, outputs, 1 bit each: sigma-delta DAC bitstreams.

Function
REQ-011 States SHALL be IDLE, ACC and OUT.
REQ-012 IDLE with `ce`=1 SHALL:
- snapshot `a1`..`c2`, `beep` and `mode`;
- clear both 15-bit accumulators;
- go to ACC, step 0.
REQ-013 ACC SHALL add one source per clock in the order A1, B1, C1, A2, B2, C2, BEEP (steps 0-6), then go to OUT.
REQ-014 Mono SHALL add each channel at full value to both accumulators.
REQ-015 ABC SHALL add:
- A at full value to left only;
- C at full value to right only;
- B, shifted right by 1 (truncated), to both.
REQ-016 ACB SHALL add:
- A at full value to left only;
- B at full value to right only;
- C, shifted right by 1 (truncated), to both.
REQ-017 BEEP SHALL add 4095 to both accumulators when the snapshot beeper is 1, else 0.
REQ-018 OUT SHALL:
- saturate each accumulator to 16383;
- register the results to `left`/`right`;
- assert `valid` for one cycle;
- return to IDLE.
REQ-019 Latency SHALL be fixed: `ce` in cycle 0 gives `valid` in cycle 8.
REQ-020 `ce` asserted in ACC or OUT SHALL be ignored, with no queuing.
REQ-021 Input or `mode` changes after the snapshot SHALL NOT affect the sequence in progress.
REQ-022 `left`/`right` SHALL hold their values between `valid` pulses.
REQ-023 Each DAC SHALL be a first-order sigma-delta:
- 15-bit accumulator, updated every clock;
- acc <= acc[13:0] + sample;
- bit 14 of the sum is the `pdm` output.

Reset
REQ-024 `reset`=0 SHALL force, at the next clock edge:
- state to IDLE and step to 0;
- accumulators, `left`, `right`, `valid`, `pdm_l`, `pdm_r` and DAC accumulators to 0.
REQ-025 A reset during ACC or OUT SHALL abort the sequence without producing a `valid` pulse.
REQ-026 The first `ce` after reset is released SHALL start a fresh sequence.

Configuration
REQ-027 With TURBOSOUND_EN defined, steps 3-5 SHALL add A2/B2/C2 per REQ-014 to REQ-016.
REQ-028 Without TURBOSOUND_EN, steps 3-5 SHALL add 0, the ports SHALL remain present but be ignored, and latency SHALL be unchanged.

Structure
REQ-029 A shared package SHALL hold:
- the mode encodings MODE_MONO, MODE_ABC, MODE_ACB;
- the state enum;
- the constants SAT_MAX=16383 and BEEP_LEVEL=4095.
REQ-030 The DAC SHALL be a single sub-module, `sigma_delta_dac`, parameterised by width 14 and instantiated twice.

Verification
REQ-031 Mode ABC, a1=4095, all other inputs 0, `ce` pulse -> cycle 8: left=4095, right=0, `valid`=1 for one cycle.
REQ-032 Mode ACB, c1=1000, all other inputs 0 -> left=500, right=500.
REQ-033 Mono, all six channels 4095 and beep=1 -> left=right=16383 (saturated).
REQ-034 `ce` pulses at cycles 0 and 3 -> exactly one `valid` pulse, at cycle 8. Separately, reset asserted at cycle 4 -> no `valid` pulse, and outputs read 0.
REQ-035 Build without TURBOSOUND_EN, mono, a2=4095, all others 0 -> left=right=0, `valid` at cycle 8.
REQ-036 Constant left=8192 for 1024 clocks -> `pdm_l` ones count = 512 ±1.
